// File: rtl/periph_pkg.sv
// Shared types and default region map for the peripheral bus controller.
package periph_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int DEF_NUM_REGIONS = 3;

   // Region 0 (ROM) in the LSBs, then GPIO, then stack RAM.
   localparam logic [3*32-1:0] DEF_REGION_BASE  = {32'h7FFF_E000, 32'h1001_0000, 32'h0040_0000};
   localparam logic [3*32-1:0] DEF_REGION_MASK  = {32'hFFFF_E000, 32'hFFFF_FF00, 32'hFFFF_0000};
   localparam logic [3*2-1:0]  DEF_REGION_SHIFT = {2'd2, 2'd0, 2'd2};

   // Counter width able to hold TIMEOUT-1.
   function automatic int timeout_cnt_w(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/periph_region_match.sv
// Address decoder: base/mask compare, lowest-index priority, offset translation.
module periph_region_match
   import periph_pkg::*;
#(
   parameter int                           NUM_REGIONS  = DEF_NUM_REGIONS,
   parameter int                           AW           = 32,
   parameter logic [NUM_REGIONS*AW-1:0]    REGION_BASE  = DEF_REGION_BASE,
   parameter logic [NUM_REGIONS*AW-1:0]    REGION_MASK  = DEF_REGION_MASK,
   parameter logic [NUM_REGIONS*2-1:0]     REGION_SHIFT = DEF_REGION_SHIFT
) (
   input  logic [AW-1:0]          addr,
   output logic [NUM_REGIONS-1:0] match,
   output logic [AW-1:0]          xlat_addr
);

   logic [NUM_REGIONS-1:0] hit_raw;

   // Raw per-region compare; overlapping regions may all hit here.
   always_comb begin
      hit_raw = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         hit_raw[i] = ((addr & REGION_MASK[i*AW +: AW]) == REGION_BASE[i*AW +: AW]);
      end
   end

   // Walk from the top index down so the lowest hitting region is the last writer.
   always_comb begin
      match     = '0;
      xlat_addr = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (hit_raw[i]) begin
            match     = '0;
            match[i]  = 1'b1;
            xlat_addr = (addr & ~REGION_MASK[i*AW +: AW]) >> REGION_SHIFT[i*2 +: 2];
         end
      end
   end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Sequential peripheral bus controller: decode, select one slave, wait for ack
// or timeout, return a one-cycle registered response.
//
// state  | meaning
// IDLE   | ready for a CPU request; decode and latch it on cpu_req
// ACCESS | slave selected, signals held, counting toward timeout
// RESP   | cpu_rvalid for one cycle with latched rdata/err
module periph_bus_ctrl
   import periph_pkg::*;
#(
   parameter int                           NUM_REGIONS  = DEF_NUM_REGIONS,
   parameter int                           AW           = 32,
   parameter int                           DW           = 32,
   parameter logic [NUM_REGIONS*AW-1:0]    REGION_BASE  = DEF_REGION_BASE,
   parameter logic [NUM_REGIONS*AW-1:0]    REGION_MASK  = DEF_REGION_MASK,
   parameter logic [NUM_REGIONS*2-1:0]     REGION_SHIFT = DEF_REGION_SHIFT,
   parameter int                           TIMEOUT      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cpu_req,
   input  logic                      cpu_we,
   input  logic [AW-1:0]             cpu_addr,
   input  logic [DW-1:0]             cpu_wdata,
   output logic                      cpu_ready,
   output logic                      cpu_rvalid,
   output logic [DW-1:0]             cpu_rdata,
   output logic                      cpu_err,
   output logic [NUM_REGIONS-1:0]    slv_sel,
   output logic                      slv_we,
   output logic [AW-1:0]             slv_addr,
   output logic [DW-1:0]             slv_wdata,
   input  logic [NUM_REGIONS-1:0]    slv_ack,
   input  logic [NUM_REGIONS*DW-1:0] slv_rdata
);

   localparam int               CNT_W    = timeout_cnt_w(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic [NUM_REGIONS-1:0] sel_q, sel_d;
   logic                   we_q, we_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [DW-1:0]          wdata_q, wdata_d;
   logic [DW-1:0]          rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [NUM_REGIONS-1:0] match_vec;
   logic [AW-1:0]          xlat_addr;
   logic                   ack_hit;
   logic [DW-1:0]          ack_rdata;

   periph_region_match #(
      .NUM_REGIONS  (NUM_REGIONS),
      .AW           (AW),
      .REGION_BASE  (REGION_BASE),
      .REGION_MASK  (REGION_MASK),
      .REGION_SHIFT (REGION_SHIFT)
   ) u_match (
      .addr      (cpu_addr),
      .match     (match_vec),
      .xlat_addr (xlat_addr)
   );

   // Only the latched slave's ack counts; others are ignored.
   always_comb begin
      ack_hit = |(slv_ack & sel_q);
   end

   // Mux the latched slave's read data out of the packed bus (sel_q is one-hot).
   always_comb begin
      ack_rdata = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (sel_q[i]) begin
            ack_rdata = ack_rdata | slv_rdata[i*DW +: DW];
         end
      end
   end

   // Next-state and datapath-register update.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (cpu_req) begin
               we_d    = cpu_we;
               wdata_d = cpu_wdata;
               sel_d   = match_vec;
               addr_d  = xlat_addr;
               if (|match_vec) begin
                  state_d = ACCESS;
               end else begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = RESP;
               end
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            // Ack is checked first so an ack on the last allowed cycle still succeeds.
            if (ack_hit) begin
               rdata_d = we_q ? '0 : ack_rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched request, response and timeout counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sel_q   <= sel_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cpu_ready  = (state_q == IDLE);
   assign cpu_rvalid = (state_q == RESP);
   assign cpu_rdata  = rdata_q;
   assign cpu_err    = err_q;
   assign slv_sel    = (state_q == ACCESS) ? sel_q : '0;
   assign slv_we     = (state_q == ACCESS) & we_q;
   assign slv_addr   = addr_q;
   assign slv_wdata  = wdata_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Self-checking bench for periph_bus_ctrl: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_periph_bus_ctrl;

   localparam int NR = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             cpu_req, cpu_we;
   logic [AW-1:0]    cpu_addr;
   logic [DW-1:0]    cpu_wdata;
   logic             cpu_ready, cpu_rvalid, cpu_err;
   logic [DW-1:0]    cpu_rdata;
   logic [NR-1:0]    slv_sel;
   logic             slv_we;
   logic [AW-1:0]    slv_addr;
   logic [DW-1:0]    slv_wdata;
   logic [NR-1:0]    slv_ack;
   logic [NR*DW-1:0] slv_rdata;

   logic             ovl_ready, ovl_rvalid, ovl_err, ovl_we;
   logic [DW-1:0]    ovl_rdata, ovl_wdata;
   logic [NR-1:0]    ovl_sel;
   logic [AW-1:0]    ovl_addr;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference region map (region 0 = ROM, 1 = GPIO, 2 = stack).
   logic [31:0] m_base  [NR] = '{32'h0040_0000, 32'h1001_0000, 32'h7FFF_E000};
   logic [31:0] m_mask  [NR] = '{32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_E000};
   int          m_shift [NR] = '{2, 0, 2};

   always #5 clk = ~clk;

   periph_bus_ctrl #(.NUM_REGIONS(NR), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr),
      .slv_wdata(slv_wdata), .slv_ack(slv_ack), .slv_rdata(slv_rdata)
   );

   // Second instance where region 2 duplicates region 0's window.
   periph_bus_ctrl #(
      .NUM_REGIONS(NR), .AW(AW), .DW(DW), .TIMEOUT(TO),
      .REGION_BASE({32'h0040_0000, 32'h1001_0000, 32'h0040_0000})
   ) u_ovl (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(ovl_ready),
      .cpu_rvalid(ovl_rvalid), .cpu_rdata(ovl_rdata), .cpu_err(ovl_err),
      .slv_sel(ovl_sel), .slv_we(ovl_we), .slv_addr(ovl_addr),
      .slv_wdata(ovl_wdata), .slv_ack(slv_ack), .slv_rdata(slv_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // First matching region in index order, or -1 when unmapped.
   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < NR; i++) begin
         if ((a & m_mask[i]) == m_base[i]) return i;
      end
      return -1;
   endfunction

   // One full CPU transaction. ack_cyc: cycle after accept in which the slave acks
   // (1 = same cycle select appears); 0 or > TO means never.
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_cyc, input logic [31:0] ack_data,
                          input bit spur, input bit chk_ovl);
      int          ri;
      int          resp_cyc;
      int          guard;
      int          other;
      bit          tmo;
      logic [31:0] exp_addr;
      logic [31:0] exp_rdata;
      ri = decode(addr);
      guard = 0;
      while (!cpu_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!cpu_ready) chk("ready_wait", 32'(cpu_ready), 32'd1);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      @(negedge clk);
      cpu_req   = 1'b0;
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      if (ri < 0) begin
         chk("miss_rvalid", 32'(cpu_rvalid), 32'd1);
         chk("miss_err",    32'(cpu_err),    32'd1);
         chk("miss_rdata",  cpu_rdata,       32'd0);
         chk("miss_sel",    32'(slv_sel),    32'd0);
         @(negedge clk);
         chk("miss_ready",  32'(cpu_ready),  32'd1);
         return;
      end
      exp_addr = (addr & ~m_mask[ri]) >> m_shift[ri];
      tmo      = (ack_cyc < 1 || ack_cyc > TO);
      resp_cyc = tmo ? TO + 1 : ack_cyc + 1;
      for (int c = 1; c < resp_cyc; c++) begin
         chk("sel",    32'(slv_sel),    32'(1 << ri));
         chk("rvalid0", 32'(cpu_rvalid), 32'd0);
         chk("wdata",  slv_wdata,       we ? wdata : slv_wdata);
         if (c == 1) begin
            chk("slv_addr", slv_addr,     exp_addr);
            chk("slv_we",   32'(slv_we),  32'(we));
            chk("ready0",   32'(cpu_ready), 32'd0);
            if (chk_ovl) chk("ovl_sel", 32'(ovl_sel), 32'd1);
         end
         slv_rdata = {$urandom, $urandom, $urandom};
         slv_ack   = '0;
         if (c == ack_cyc) begin
            slv_ack[ri] = 1'b1;
            slv_rdata[ri*DW +: DW] = ack_data;
         end else if (spur) begin
            other = (ri + 1 + $urandom_range(0, NR - 2)) % NR;
            slv_ack[other] = 1'b1;
         end
         @(negedge clk);
      end
      slv_ack   = '0;
      exp_rdata = (tmo || we) ? 32'd0 : ack_data;
      chk("rvalid",    32'(cpu_rvalid), 32'd1);
      chk("err",       32'(cpu_err),    32'(tmo));
      chk("rdata",     cpu_rdata,       exp_rdata);
      chk("resp_ready", 32'(cpu_ready), 32'd0);
      chk("resp_sel",  32'(slv_sel),    32'd0);
      @(negedge clk);
      chk("rvalid_1cyc", 32'(cpu_rvalid), 32'd0);
      chk("idle_ready",  32'(cpu_ready),  32'd1);
   endtask

   initial begin
      int          r, ac, sel;
      logic [31:0] a;
      reset     = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      slv_ack   = '0;
      slv_rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready",  32'(cpu_ready),  32'd1);
      chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_err",    32'(cpu_err),    32'd0);
      chk("rst_rdata",  cpu_rdata,       32'd0);
      chk("rst_sel",    32'(slv_sel),    32'd0);
      chk("rst_we",     32'(slv_we),     32'd0);
      chk("rst_addr",   slv_addr,        32'd0);
      chk("rst_wdata",  slv_wdata,       32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_txn(1'b0, 32'h0040_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      run_txn(1'b1, 32'h1001_0024, 32'h5A, 3, 32'h1234_5678, 1'b0, 1'b0);
      run_txn(1'b0, 32'h2000_0000, 32'h0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_txn(1'b0, 32'h7FFF_E008, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
      run_txn(1'b0, 32'h7FFF_E100, 32'h0, TO, 32'hA5A5_0F0F, 1'b0, 1'b0);
      run_txn(1'b0, 32'h0040_0000, 32'h0, 2, 32'h0BAD_CAFE, 1'b1, 1'b1);

      // Reset in the middle of a pending stack access.
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h7FFF_E010;
      @(negedge clk);
      cpu_req = 1'b0;
      chk("pre_rst_sel", 32'(slv_sel), 32'd4);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_sel",    32'(slv_sel),    32'd0);
      chk("mid_rst_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("mid_rst_ready",  32'(cpu_ready),  32'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_txn(1'b0, 32'h0040_0020, 32'h0, 2, 32'h600D_0001, 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(0, NR);
         if (r < NR) a = m_base[r] | ($urandom & ~m_mask[r]);
         else        a = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0)      ac = 0;
         else if (sel == 1) ac = TO;
         else               ac = $urandom_range(1, 5);
         run_txn(1'($urandom), a, $urandom, ac, $urandom, 1'($urandom), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
